// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, decoder state encoding and helpers
package vga_pkg;
  localparam int H_TOTAL_DEF = 793;
  localparam int V_TOTAL_DEF = 525;
  localparam int H_ACTIVE_START_DEF = 145;
  localparam int V_ACTIVE_START_DEF = 36;
  localparam int LOCK_FRAMES_DEF = 2;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction
endpackage

// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: raw sync inputs and recovered timing outputs of the decoder
interface vga_sync_decoder_if;
  logic pix_en;
  logic VGA_HS;
  logic VGA_VS;
  logic [10:0] x;
  logic [10:0] y;
  logic ativo;
  logic locked;
  logic frame_start;
  logic [10:0] h_len;
  logic [10:0] v_len;
  logic [7:0] err_cnt;
  modport master (
    output pix_en, VGA_HS, VGA_VS,
    input  x, y, ativo, locked, frame_start, h_len, v_len, err_cnt
  );
  modport slave (
    input  pix_en, VGA_HS, VGA_VS,
    output x, y, ativo, locked, frame_start, h_len, v_len, err_cnt
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // first flop may go metastable, second hands a settled value to the core
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers x/y position, active video and lock status from VGA syncs
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int H_ACTIVE_START = H_ACTIVE_START_DEF,
  parameter int V_ACTIVE_START = V_ACTIVE_START_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input logic CLOCK_50,
  input logic RESET_N,
  vga_sync_decoder_if.slave bus
);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [10:0] HA = 11'(H_ACTIVE_START);
  localparam logic [10:0] VA = 11'(V_ACTIVE_START);
  localparam logic [7:0] LF = 8'(LOCK_FRAMES);
  localparam logic [11:0] WD = 12'(2 * H_TOTAL);

  logic hs_s, vs_s, hs_prev, vs_prev;
  logic hs_fall, vs_fall, line_bad, wd_fire;
  logic [10:0] x_inc, y_inc, x_n, y_n, h_len_n, v_len_n;
  logic [7:0] good, good_n, err_n;
  logic [11:0] wd, wd_n;
  logic line_err, line_err_n, locked_n, ativo_n;
  state_t state, state_n;

  sync_2ff #(.RST_VAL(1'b1)) u_hs_sync (.clk(CLOCK_50), .rst_n(RESET_N), .d(bus.VGA_HS), .q(hs_s));
  sync_2ff #(.RST_VAL(1'b1)) u_vs_sync (.clk(CLOCK_50), .rst_n(RESET_N), .d(bus.VGA_VS), .q(vs_s));

  // counters, edge detection and lock FSM next-state; a VS fall always wins over an HS-only fall
  always_comb begin
    hs_fall = bus.pix_en && hs_prev && !hs_s;
    vs_fall = bus.pix_en && vs_prev && !vs_s;
    x_inc = sat_inc(bus.x);
    y_inc = sat_inc(bus.y);
    line_bad = hs_fall && x_inc != HT;
    x_n = !bus.pix_en ? bus.x : hs_fall ? 11'd0 : x_inc;
    y_n = !bus.pix_en ? bus.y : vs_fall ? 11'd0 : hs_fall ? y_inc : bus.y;
    h_len_n = hs_fall ? x_inc : bus.h_len;
    v_len_n = vs_fall ? y_inc : bus.v_len;
    wd_n = !bus.pix_en ? wd : hs_fall ? 12'd0 : wd + 12'd1;
    wd_fire = bus.pix_en && !hs_fall && wd_n == WD;
    state_n = state;
    good_n = good;
    line_err_n = line_err;
    err_n = bus.err_cnt;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_n = ACQUIRE;
          good_n = 8'd0;
          line_err_n = 1'b0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          good_n = (y_inc == VT && !line_err && !line_bad) ? good + 8'd1 : 8'd0;
          line_err_n = 1'b0;
          state_n = (good_n == LF) ? LOCKED : ACQUIRE;
        end else if (line_bad) begin
          line_err_n = 1'b1;
        end
      end
      LOCKED: state_n = (line_bad || (vs_fall && y_inc != VT)) ? SEARCH : LOCKED;
      default: state_n = SEARCH;
    endcase
    if (wd_fire) state_n = SEARCH;
    if (state == LOCKED && state_n == SEARCH && bus.err_cnt != 8'hff) err_n = bus.err_cnt + 8'd1;
    locked_n = state_n == LOCKED;
    ativo_n = locked_n && x_n >= HA && y_n >= VA && x_n < HT && y_n < VT;
  end

  // state and every output are registered; ativo is built from the same next values as x/y/locked
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      state <= SEARCH;
      good <= 8'd0;
      line_err <= 1'b0;
      wd <= 12'd0;
      bus.x <= 11'd0;
      bus.y <= 11'd0;
      bus.h_len <= 11'd0;
      bus.v_len <= 11'd0;
      bus.ativo <= 1'b0;
      bus.locked <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.err_cnt <= 8'd0;
    end else begin
      hs_prev <= bus.pix_en ? hs_s : hs_prev;
      vs_prev <= bus.pix_en ? vs_s : vs_prev;
      state <= state_n;
      good <= good_n;
      line_err <= line_err_n;
      wd <= wd_fire ? 12'd0 : wd_n;
      bus.x <= x_n;
      bus.y <= y_n;
      bus.h_len <= h_len_n;
      bus.v_len <= v_len_n;
      bus.ativo <= ativo_n;
      bus.locked <= locked_n;
      bus.frame_start <= vs_fall;
      bus.err_cnt <= err_n;
    end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_TOTAL, default 793: expected pixel samples per line, counted from one HS falling edge to the next.
REQ-002 Parameter V_TOTAL, default 525: expected lines per frame, counted from one VS falling edge to the next.
REQ-003 Parameter H_ACTIVE_START, default 145: first active x.
REQ-004 Parameter V_ACTIVE_START, default 36: first active y.
REQ-005 Parameter LOCK_FRAMES, default 2: consecutive good frames required to lock.
REQ-006 CLOCK_50  in  1  sole clock, rising edge.
REQ-007 RESET_N  in  1  asynchronous, active-low reset.
REQ-008 pix_en  in  1  pixel-sample strobe, one CLOCK_50 cycle wide.
REQ-009 VGA_HS  in  1  horizontal sync, active-low, may be asynchronous.
REQ-010 VGA_VS  in  1  vertical sync, active-low, may be asynchronous.
REQ-011 x  out  11  recovered pixel column.
REQ-012 y  out  11  recovered line.
REQ-013 ativo  out  1  recovered active-video flag.
REQ-014 locked  out  1  timing matches H_TOTAL/V_TOTAL.
REQ-015 frame_start  out  1  one-cycle pulse on each qualified VS falling edge.
REQ-016 h_len  out  11  length of the last completed line.
REQ-017 v_len  out  11  line count of the last completed frame.
REQ-018 err_cnt  out  8  lock-loss counter, saturating at 255.

Function
REQ-019 VGA_HS and VGA_VS SHALL pass through a 2-FF synchronizer; only synchronized values are used.
REQ-020 All state SHALL update only on cycles with pix_en=1; edges are detected between consecutive pix_en samples.
REQ-021 HS falling sample: x<=0 and h_len<=x+1; all other samples: x<=x+1, saturating at 2047.
REQ-022 VS falling sample: y<=0, v_len<=y+1, frame_start=1 for that cycle; HS-only falling sample: y<=y+1, saturating at 2047; simultaneous HS and VS fall SHALL be treated as VS fall.
REQ-023 FSM states: SEARCH, ACQUIRE, LOCKED; reset state SEARCH.
REQ-024 SEARCH->ACQUIRE on the first VS fall; clear the good-frame count and the line-error flag.
REQ-025 ACQUIRE: any completed line with h_len!=H_TOTAL sets the line-error flag.
REQ-026 ACQUIRE, at each VS fall: if v_len==V_TOTAL and the flag is clear, increment the good-frame count, else zero it; clear the flag.
REQ-027 ACQUIRE->LOCKED when the good-frame count reaches LOCK_FRAMES; locked=1 from the cycle after that VS fall.
REQ-028 LOCKED->SEARCH at the HS fall ending a line !=H_TOTAL, or at the VS fall ending a frame !=V_TOTAL; locked=0 the next cycle; err_cnt+1.
REQ-029 Watchdog: 2*H_TOTAL consecutive samples with no HS fall SHALL force SEARCH from any state; err_cnt+1 only if the FSM was in LOCKED.
REQ-030 ativo SHALL equal locked && x>=H_ACTIVE_START && y>=V_ACTIVE_START && x<H_TOTAL && y<V_TOTAL.
REQ-031 All outputs SHALL be registered.
REQ-032 Latency: an edge on a raw sync pin affects x/y by at most 2 sync cycles + 1 pix_en interval + 1 cycle.

Reset
REQ-033 RESET_N low SHALL immediately set x=0, y=0, ativo=0, locked=0, frame_start=0, h_len=0, v_len=0, err_cnt=0, FSM=SEARCH, synchronizer flops=1.
REQ-034 Reset mid-frame SHALL discard all progress; relock SHALL require the full SEARCH/ACQUIRE sequence.

Structure
REQ-035 Package vga_pkg SHALL hold H_TOTAL/V_TOTAL/active-start defaults and the FSM state enumeration.
REQ-036 The synchronizer SHALL be sub-module sync_2ff (1 bit, reset value parameter), instantiated once per sync input.

Verification
REQ-037 RESET_N=0 with stimulus running -> all outputs at the REQ-033 values within 1 cycle.
REQ-038 Nominal 793x525 stream, pix_en every 2nd cycle -> locked=1 after the 3rd VS fall; h_len=793; v_len=525; one frame_start per frame.
REQ-039 While locked -> ativo=1 at (x=145, y=36); ativo=0 at x=144 and at y=35.
REQ-040 While locked, inject one 794-sample line -> locked=0 after that HS fall; err_cnt=1; relock after 2 further good frames.
REQ-041 While locked, hold VGA_HS high for 1600 samples -> watchdog drops locked at sample 1586; err_cnt increments.
REQ-042 Assert RESET_N at line 200 of frame 5 -> outputs cleared; locked=1 again only after the 3rd subsequent VS fall.
